if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the program counter and drives the instruction-memory address.
- Captures the fetched word into the IF/ID pipeline register.
- Honours a stall from the hazard unit and a flush/redirect from a branch resolved in ID. It feeds the decode stage, which reads the register file.

---
 rtl/if_stage.sv | 66 ++++++
 tb/tb_if_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: RISC-V instruction fetch stage with PC, IF/ID register, stall/flush handling and fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic [31:0] fetch_count_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_n;
  logic [31:0] pc_n, ifid_pc_n, ifid_instr_n, fetch_count_n;
  logic        ifid_valid_n, bubble, load;
  assign imem_addr_o = pc_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      pc_o          <= RESET_PC;
      ifid_pc_o     <= '0;
      ifid_instr_o  <= NOP_INSTR;
      ifid_valid_o  <= 1'b0;
      fetch_count_o <= '0;
    end else begin
      state         <= state_n;
      pc_o          <= pc_n;
      ifid_pc_o     <= ifid_pc_n;
      ifid_instr_o  <= ifid_instr_n;
      ifid_valid_o  <= ifid_valid_n;
      fetch_count_o <= fetch_count_n;
    end
  end
  // Priority in RUN: stop > flush > stall > normal fetch; IDLE ignores flush and stall.
  always_comb begin
    state_n = state;
    bubble  = 1'b0;
    load    = 1'b0;
    pc_n    = pc_o;
    if (state == IDLE) begin
      state_n = start_i ? RUN : IDLE;
      bubble  = 1'b1;
    end else if (!start_i) begin
      state_n = IDLE;
      bubble  = 1'b1;
    end else if (flush_i) begin
      pc_n   = branch_target_i & ~32'h3;
      bubble = 1'b1;
    end else if (!stall_i) begin
      pc_n = pc_o + 32'd4;
      load = 1'b1;
    end
    ifid_pc_n     = bubble ? 32'h0 : load ? pc_o : ifid_pc_o;
    ifid_instr_n  = bubble ? NOP_INSTR : load ? imem_instr_i : ifid_instr_o;
    ifid_valid_n  = bubble ? 1'b0 : load ? 1'b1 : ifid_valid_o;
    fetch_count_n = load ? fetch_count_o + 32'd1 : fetch_count_o;
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: vector table, wrap sequence and randomized model comparison for if_stage.
module tb_if_stage;
  logic        clk = 0, rst = 0, start = 0, stall = 0, flush = 0;
  logic [31:0] target = 0;
  logic [31:0] addr, instr, pc, ifid_pc, ifid_instr, cnt;
  logic        ifid_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_ifid_pc, w_ifid_instr, w_cnt;
  logic        w_valid;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign instr   = addr + 32'h100;
  assign w_instr = w_addr + 32'h100;

  if_stage dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(target), .imem_addr_o(addr), .imem_instr_i(instr), .pc_o(pc),
    .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr), .ifid_valid_o(ifid_valid), .fetch_count_o(cnt)
  );
  if_stage #(.RESET_PC(32'hFFFFFFF8)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(target), .imem_addr_o(w_addr), .imem_instr_i(w_instr), .pc_o(w_pc),
    .ifid_pc_o(w_ifid_pc), .ifid_instr_o(w_ifid_instr), .ifid_valid_o(w_valid), .fetch_count_o(w_cnt)
  );

  typedef struct {
    logic        rst, start, stall, flush;
    logic [31:0] target, pc, ifid_pc, instr;
    logic        valid;
    logic [31:0] cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic st, input logic f, input logic [31:0] t);
    @(negedge clk);
    rst = r; start = s; stall = st; flush = f; target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                         input logic [31:0] e_ins, input logic e_v, input logic [31:0] e_cnt);
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " imem_addr"}, addr, e_pc);
    chk({tag, " ifid_pc"}, ifid_pc, e_ipc);
    chk({tag, " ifid_instr"}, ifid_instr, e_ins);
    chk({tag, " ifid_valid"}, {31'b0, ifid_valid}, {31'b0, e_v});
    chk({tag, " count"}, cnt, e_cnt);
  endtask

  // Reference model: spec rules expressed directly on abstract variables.
  bit          m_run;
  logic [31:0] m_pc, m_ipc, m_ins, m_cnt;
  logic        m_v;
  task automatic model_step();
    if (rst) begin
      m_run = 0; m_pc = 0; m_ipc = 0; m_ins = 32'h13; m_v = 0; m_cnt = 0;
    end else if (!m_run || !start || flush) begin
      if (m_run && start) m_pc = {target[31:2], 2'b00};
      m_run = start;
      m_ipc = 0; m_ins = 32'h13; m_v = 0;
    end else if (!stall) begin
      m_ipc = m_pc; m_ins = m_pc + 32'h100; m_v = 1;
      m_pc += 4; m_cnt += 1;
    end
  endtask

  vec_t vt[$];
  initial begin
    //        rst start stall flush target     pc           ifid_pc  instr         v  cnt
    vt.push_back('{1, 0, 0, 0, 32'h0,  32'h0,  32'h0,  32'h13,  0, 0});
    vt.push_back('{0, 1, 0, 0, 32'h0,  32'h0,  32'h0,  32'h13,  0, 0});
    vt.push_back('{0, 1, 0, 0, 32'h0,  32'h4,  32'h0,  32'h100, 1, 1});
    vt.push_back('{0, 1, 0, 0, 32'h0,  32'h8,  32'h4,  32'h104, 1, 2});
    vt.push_back('{0, 1, 1, 0, 32'h0,  32'h8,  32'h4,  32'h104, 1, 2});
    vt.push_back('{0, 1, 1, 0, 32'h0,  32'h8,  32'h4,  32'h104, 1, 2});
    vt.push_back('{0, 1, 0, 0, 32'h0,  32'hC,  32'h8,  32'h108, 1, 3});
    vt.push_back('{0, 1, 0, 1, 32'h40, 32'h40, 32'h0,  32'h13,  0, 3});
    vt.push_back('{0, 1, 0, 0, 32'h0,  32'h44, 32'h40, 32'h140, 1, 4});
    vt.push_back('{0, 1, 1, 1, 32'h23, 32'h20, 32'h0,  32'h13,  0, 4});
    vt.push_back('{0, 1, 1, 0, 32'h0,  32'h20, 32'h0,  32'h13,  0, 4});
    vt.push_back('{1, 1, 1, 0, 32'h0,  32'h0,  32'h0,  32'h13,  0, 0});
    vt.push_back('{0, 1, 1, 1, 32'h80, 32'h0,  32'h0,  32'h13,  0, 0});
    vt.push_back('{0, 1, 0, 0, 32'h0,  32'h4,  32'h0,  32'h100, 1, 1});
    vt.push_back('{0, 0, 0, 0, 32'h0,  32'h4,  32'h0,  32'h13,  0, 1});
    vt.push_back('{0, 0, 1, 1, 32'h60, 32'h4,  32'h0,  32'h13,  0, 1});
    vt.push_back('{0, 1, 0, 0, 32'h0,  32'h4,  32'h0,  32'h13,  0, 1});
    vt.push_back('{0, 1, 0, 0, 32'h0,  32'h8,  32'h4,  32'h104, 1, 2});
    foreach (vt[i]) begin
      cyc(vt[i].rst, vt[i].start, vt[i].stall, vt[i].flush, vt[i].target);
      chk_all($sformatf("vec%0d", i), vt[i].pc, vt[i].ifid_pc, vt[i].instr, vt[i].valid, vt[i].cnt);
    end

    // PC wrap from RESET_PC = FFFFFFF8
    cyc(1, 0, 0, 0, 0);
    chk("wrap reset pc", w_pc, 32'hFFFFFFF8);
    cyc(0, 1, 0, 0, 0);
    chk("wrap run pc", w_pc, 32'hFFFFFFF8);
    cyc(0, 1, 0, 0, 0);
    chk("wrap pc1", w_pc, 32'hFFFFFFFC);
    chk("wrap ifid_pc1", w_ifid_pc, 32'hFFFFFFF8);
    cyc(0, 1, 0, 0, 0);
    chk("wrap pc2", w_pc, 32'h0);
    chk("wrap ifid_pc2", w_ifid_pc, 32'hFFFFFFFC);
    cyc(0, 1, 0, 0, 0);
    chk("wrap pc3", w_pc, 32'h4);
    chk("wrap ifid_instr3", w_ifid_instr, 32'h100);
    chk("wrap count3", w_cnt, 32'd3);

    // Randomized run against the model
    cyc(1, 0, 0, 0, 0);
    model_step();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 49) == 0);
      start  = ($urandom_range(0, 9) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      target = $urandom;
      @(posedge clk);
      model_step();
      #1;
      chk_all($sformatf("rand%0d", i), m_pc, m_ipc, m_ins, m_v, m_cnt);
      chk("rand pc_align", {30'b0, pc[1:0]}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
